// File: rtl/music_pkg.sv
// Shared musical constants: note divider table, rest code and player state encoding.
// No timing of its own; pure constants and combinational helper functions.
// No flow control.
package music_pkg;

  // Codes 12..15 are all rests; 12 is the canonical one.
  localparam logic [3:0] NOTE_REST = 4'd12;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  // Half-period divider per note code (A .. G#). Rest codes never reach the
  // tone counters' output, so their table entry only has to be a legal value.
  function automatic logic [9:0] note_divider(input logic [3:0] code);
    case (code)
      4'd0:    note_divider = 10'd512;
      4'd1:    note_divider = 10'd483;
      4'd2:    note_divider = 10'd456;
      4'd3:    note_divider = 10'd431;
      4'd4:    note_divider = 10'd406;
      4'd5:    note_divider = 10'd384;
      4'd6:    note_divider = 10'd362;
      4'd7:    note_divider = 10'd342;
      4'd8:    note_divider = 10'd323;
      4'd9:    note_divider = 10'd304;
      4'd10:   note_divider = 10'd287;
      4'd11:   note_divider = 10'd271;
      default: note_divider = 10'd512;
    endcase
  endfunction

  // Octave prescale: each octave up halves the period (256 .. 2).
  function automatic logic [8:0] octave_prescale(input logic [2:0] octave);
    octave_prescale = 9'd256 >> octave;
  endfunction

endpackage

// File: rtl/tone_gen.sv
// Square-wave generator: speaker toggles every divider*prescale cycles while enabled.
// Latency: first toggle divider*prescale cycles after enable rises; output gated off the same cycle enable falls.
// No flow control; code/octave must stay stable while enabled.
// Ports: clk, reset (sync, active-high), code/octave (note to play), enable (playing), speaker (audio out).
module tone_gen
  import music_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] code,
  input  logic [2:0] octave,
  input  logic       enable,
  output logic       speaker
);

  logic [9:0] div_last;
  logic [8:0] pre_last;
  logic [9:0] div_cnt;
  logic [8:0] pre_cnt;
  logic       tone_q;
  logic       is_rest;

  assign div_last = note_divider(code) - 10'd1;
  assign pre_last = octave_prescale(octave) - 9'd1;
  assign is_rest  = (code >= NOTE_REST);

  // Counters and tone sit at zero whenever disabled, so every PLAY entry
  // starts from a clean phase with speaker low.
  always_ff @(posedge clk) begin
    if (reset || !enable) begin
      pre_cnt <= 9'd0;
      div_cnt <= 10'd0;
      tone_q  <= 1'b0;
    end else if (pre_cnt == pre_last) begin
      pre_cnt <= 9'd0;
      if (div_cnt == div_last) begin
        div_cnt <= 10'd0;
        tone_q  <= ~tone_q;
      end else begin
        div_cnt <= div_cnt + 10'd1;
      end
    end else begin
      pre_cnt <= pre_cnt + 9'd1;
    end
  end

  // Gating with enable forces silence on the first cycle after PLAY, before
  // the registered tone has had a chance to clear.
  assign speaker = tone_q & enable & ~is_rest;

endmodule

// File: rtl/tune_player.sv
// Note player: accepts one note, plays it for note_len ticks, then a fixed silent gap.
// Latency: PLAY starts the cycle after acceptance; done pulses on the first IDLE cycle after the note.
// Backpressure: note_ready is high only in IDLE; note_valid at any other time is ignored, not held.
// Ports: clk, reset (sync, active-high), note_valid/note_ready handshake with note_code/note_octave/note_len,
//        speaker (square wave), busy (not IDLE), done (one-cycle completion pulse).
module tune_player
  import music_pkg::*;
#(
  parameter int CLK_HZ      = 50_000_000,
  parameter int TICK_CYCLES = 50_000,
  parameter int GAP_TICKS   = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       note_valid,
  output logic       note_ready,
  input  logic [3:0] note_code,
  input  logic [2:0] note_octave,
  input  logic [7:0] note_len,
  output logic       speaker,
  output logic       busy,
  output logic       done
);

  if (CLK_HZ < 1 || TICK_CYCLES < 1 || GAP_TICKS < 0 || GAP_TICKS > 255) begin : g_bad_params
    $error("tune_player: parameter out of range");
  end

  // Duration is split into a cycle-within-tick counter and a ticks-remaining
  // counter, which covers 255*TICK_CYCLES without a wide multiplier.
  localparam int              TICK_W    = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_CYCLES - 1);
  localparam logic [7:0]      GAP_LEN   = 8'(GAP_TICKS);

  state_t            state, state_d;
  logic [3:0]        code_q;
  logic [2:0]        oct_q;
  logic [TICK_W-1:0] tick_cnt;
  logic [7:0]        ticks_left;
  logic              done_q, done_d;
  logic              load_play, load_gap;
  logic              tick_end, last_tick;

  assign tick_end  = (tick_cnt == TICK_LAST);
  assign last_tick = tick_end && (ticks_left == 8'd1);

  always_comb begin
    state_d   = state;
    done_d    = 1'b0;
    load_play = 1'b0;
    load_gap  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (note_valid) begin
          if (note_len != 8'd0) begin
            state_d   = ST_PLAY;
            load_play = 1'b1;
          end else if (GAP_LEN != 8'd0) begin
            state_d  = ST_GAP;
            load_gap = 1'b1;
          end else begin
            // Nothing to play and no gap: the note completes immediately.
            done_d = 1'b1;
          end
        end
      end
      ST_PLAY: begin
        if (last_tick) begin
          if (GAP_LEN != 8'd0) begin
            state_d  = ST_GAP;
            load_gap = 1'b1;
          end else begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      ST_GAP: begin
        if (last_tick) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      done_q     <= 1'b0;
      code_q     <= 4'd0;
      oct_q      <= 3'd0;
      tick_cnt   <= '0;
      ticks_left <= 8'd0;
    end else begin
      state  <= state_d;
      done_q <= done_d;
      if (state == ST_IDLE && note_valid) begin
        code_q <= note_code;
        oct_q  <= note_octave;
      end
      if (load_play) begin
        tick_cnt   <= '0;
        ticks_left <= note_len;
      end else if (load_gap) begin
        tick_cnt   <= '0;
        ticks_left <= GAP_LEN;
      end else if (state != ST_IDLE) begin
        tick_cnt <= tick_end ? '0 : tick_cnt + TICK_W'(1);
        if (tick_end) begin
          ticks_left <= ticks_left - 8'd1;
        end
      end
    end
  end

  assign note_ready = (state == ST_IDLE);
  assign busy       = (state != ST_IDLE);
  assign done       = done_q;

  tone_gen u_tone (
    .clk     (clk),
    .reset   (reset),
    .code    (code_q),
    .octave  (oct_q),
    .enable  (state == ST_PLAY),
    .speaker (speaker)
  );

endmodule

// File: doc/tune_player.md
TUNE_PLAYER -- requirements
Module: tune_player

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50_000_000; system clock frequency, documentation and derivation only.
REQ-002 SHALL have parameter TICK_CYCLES, default 50_000; clk cycles per duration tick (1 ms at 50 MHz).
REQ-003 SHALL have parameter GAP_TICKS, default 10; silent ticks inserted after every note, range 0..255.
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port note_valid  input  1  note request present.
REQ-007 SHALL have port note_ready  output  1  player can accept a note.
REQ-008 SHALL have port note_code  input  4  0..11 = A, A#, B, C, C#, D, D#, E, F, F#, G, G#; 12..15 = rest.
REQ-009 SHALL have port note_octave  input  3  octave 0 (lowest) ..7.
REQ-010 SHALL have port note_len  input  8  note duration in ticks.
REQ-011 SHALL have port speaker  output  1  square-wave audio output.
REQ-012 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-013 SHALL have port done  output  1  one-cycle pulse when a note (including gap) completes.

Function
REQ-014 SHALL implement FSM IDLE -> PLAY -> GAP -> IDLE; note_ready = (state==IDLE).
REQ-015 SHALL accept a note on a rising edge with note_valid && note_ready, registering code, octave and len; note_valid while not ready is ignored and not held.
REQ-016 SHALL enter PLAY on the cycle after acceptance, with note_len>0; note_len==0 goes directly to GAP.
REQ-017 SHALL remain in PLAY for exactly note_len*TICK_CYCLES cycles, then GAP for GAP_TICKS*TICK_CYCLES cycles (0 = skip GAP), then IDLE.
REQ-018 SHALL pulse done for one cycle on the IDLE-entry cycle following GAP (or PLAY if GAP_TICKS=0).
REQ-019 SHALL use note dividers D = 512, 483, 456, 431, 406, 384, 362, 342, 323, 304, 287, 271 for codes 0..11.
REQ-020 SHALL use octave prescale P = 256>>octave (256..2).
REQ-021 SHALL toggle speaker every D*P cycles during PLAY of a non-rest code, with divider and prescale counters reloaded and speaker cleared on PLAY entry; first toggle D*P cycles after entry.
REQ-022 SHALL hold speaker 0 in IDLE, GAP, and PLAY of a rest code; speaker forced 0 on the cycle leaving PLAY.
REQ-023 SHALL keep tick and duration counters wide enough for 255*TICK_CYCLES without wrap.
REQ-024 SHALL ignore input changes during PLAY/GAP; latched values only.

Reset
REQ-025 SHALL, when reset is high at a clock edge, force IDLE, speaker=0, done=0, busy=0, note_ready=1 on the following cycle, clearing all counters; applies mid-note, no pending note retained.
REQ-026 SHALL give reset priority over a simultaneous handshake, so the note is dropped.

Structure
REQ-027 SHALL place the divider table, NOTE_REST=12 and the state enum in shared package music_pkg.
REQ-028 SHALL factor tone generation (code, octave, enable -> speaker) into sub-module tone_gen; tune_player holds FSM, handshake and duration timing.

Verification (TICK_CYCLES=1024, GAP_TICKS=2)
REQ-029 SHALL verify: reset, then A oct7 len=4 -> speaker toggles every 1024 cycles, 4 toggles in 4096 PLAY cycles, speaker 0 for 2048 GAP cycles, done pulse once, busy low afterwards.
REQ-030 SHALL verify: G# oct6 len=1 -> half-period 271*4=1084 cycles > tick, so speaker stays 0 for the whole note, 1024 cycles.
REQ-031 SHALL verify: code 12 len=3 -> speaker 0 throughout, busy high 5*1024 cycles, done pulse.
REQ-032 SHALL verify: note_len=0 -> no toggles, GAP only, done after 2048 cycles; note_valid asserted during busy -> ignored, no second done.
REQ-033 SHALL verify: reset asserted mid-PLAY -> next cycle speaker=0, busy=0, note_ready=1, no done pulse; subsequent note plays normally.
